// File: rtl/operand_bypass_unit.sv
// rtl/operand_bypass_unit.sv - operand forwarding and outstanding-load scoreboard
//
// Purpose:
//   Resolves decode-stage register and predicate reads from in-flight
//   forwarding sources (index 0 youngest, highest priority), an optional
//   load-completion bypass, or the regfile. Tracks outstanding multi-cycle
//   loads per destination register and raises a decode stall on RAW, WAW
//   and load-capacity hazards.
//
// Build option:
//   OPERAND_BYPASS_LD_DONE_EN - when defined, completing load data is an
//   operand source (below all fwd sources, above the regfile), and the
//   completing cycle clears RAW/WAW/FULL hazards for that load.
//
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   rd_use/rd_addr/rf_data     decode read ports and regfile data per port
//   ps_use/rf_ps               predicate read and regfile predicate
//   fwd_use_rw/fwd_rw_addr/fwd_rw_data   forwarding register results
//   fwd_write_ps/fwd_ps_data   forwarding predicate results
//   iss_valid/iss_rw_use/iss_rw_addr/iss_is_load   instruction at decode
//   ld_done/ld_addr/ld_data    load completion
//   op_data/ps_data            resolved operands and predicate
//   stall                      hold decode this cycle
//   ld_pending/ld_count        scoreboard bits and outstanding load count

module operand_bypass_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 2,
  parameter int MAX_LD  = 4,
  localparam int CNT_W  = $clog2(MAX_LD + 1),
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_RD-1:0]         rd_use,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD*DATA_W-1:0]  rf_data,
  input  logic                      ps_use,
  input  logic                      rf_ps,
  input  logic [NUM_FWD-1:0]        fwd_use_rw,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_rw_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_rw_data,
  input  logic [NUM_FWD-1:0]        fwd_write_ps,
  input  logic [NUM_FWD-1:0]        fwd_ps_data,
  input  logic                      iss_valid,
  input  logic                      iss_rw_use,
  input  logic [ADDR_W-1:0]         iss_rw_addr,
  input  logic                      iss_is_load,
  input  logic                      ld_done,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]         ld_data,
  output logic [NUM_RD*DATA_W-1:0]  op_data,
  output logic                      ps_data,
  output logic                      stall,
  output logic [NREG-1:0]           ld_pending,
  output logic [CNT_W-1:0]          ld_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LD);

  logic [NREG-1:0] clr_mask;   // scoreboard bit being retired this cycle, if bypass on
  logic [NREG-1:0] busy_mask;  // pending loads that still block a consumer this cycle
  logic            raw_hit;
  logic            waw_hit;
  logic            full_hit;
  logic            issue_fire;
  logic            ld_set;
  logic            ld_clr;

  // Operand resolution. Lower-priority sources are written first and the
  // fwd sources are scanned from highest index down, so the lowest matching
  // j is the last write and wins.
  always_comb begin
    op_data = rf_data;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_use[i]) begin
`ifdef OPERAND_BYPASS_LD_DONE_EN
        if (ld_done && (ld_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
          op_data[i*DATA_W +: DATA_W] = ld_data;
        end
`endif
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
          if (fwd_use_rw[j] && (fwd_rw_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
            op_data[i*DATA_W +: DATA_W] = fwd_rw_data[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Predicate resolution, same priority scheme without an address match.
  always_comb begin
    ps_data = rf_ps;
    if (ps_use) begin
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
        if (fwd_write_ps[j]) begin
          ps_data = fwd_ps_data[j];
        end
      end
    end
  end

`ifdef OPERAND_BYPASS_LD_DONE_EN
  always_comb begin
    clr_mask = '0;
    if (ld_done) begin
      clr_mask[ld_addr] = 1'b1;
    end
  end

  // A completing load frees its slot in the same cycle, so a new load may
  // issue into a full scoreboard alongside it.
  assign full_hit = iss_is_load && (ld_count == MAX_CNT) && !ld_done;
`else
  assign clr_mask = '0;
  assign full_hit = iss_is_load && (ld_count == MAX_CNT);

  // Load data only feeds the operand path when the bypass is built in.
  logic unused_ld_data;
  assign unused_ld_data = ^ld_data;
`endif

  assign busy_mask = ld_pending & ~clr_mask;

  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_use[i] && busy_mask[rd_addr[i*ADDR_W +: ADDR_W]]) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign waw_hit = iss_rw_use && busy_mask[iss_rw_addr];

  assign stall      = iss_valid && (raw_hit || waw_hit || full_hit);
  assign issue_fire = iss_valid && !stall;
  assign ld_set     = issue_fire && iss_is_load && iss_rw_use;
  // A completion with nothing outstanding belongs to a load issued before
  // the last reset; it must not disturb the scoreboard.
  assign ld_clr     = ld_done && (ld_count != '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ld_pending <= '0;
      ld_count   <= '0;
    end else begin
      // Set is written after clear so it wins when both hit the same bit.
      if (ld_clr) begin
        ld_pending[ld_addr] <= 1'b0;
      end
      if (ld_set) begin
        ld_pending[iss_rw_addr] <= 1'b1;
      end
      case ({ld_set, ld_clr})
        2'b10:   ld_count <= ld_count + 1'b1;
        2'b01:   ld_count <= ld_count - 1'b1;
        default: ld_count <= ld_count;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// tb/tb_operand_bypass_unit.sv - self-checking bench for operand_bypass_unit

module tb_operand_bypass_unit;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int NUM_RD  = 2;
  localparam int NUM_FWD = 2;
  localparam int MAX_LD  = 4;
  localparam int CNT_W   = $clog2(MAX_LD + 1);
  localparam int NREG    = 2 ** ADDR_W;

  logic                      clk;
  logic                      n_rst;
  logic [NUM_RD-1:0]         rd_use;
  logic [NUM_RD*ADDR_W-1:0]  rd_addr;
  logic [NUM_RD*DATA_W-1:0]  rf_data;
  logic                      ps_use;
  logic                      rf_ps;
  logic [NUM_FWD-1:0]        fwd_use_rw;
  logic [NUM_FWD*ADDR_W-1:0] fwd_rw_addr;
  logic [NUM_FWD*DATA_W-1:0] fwd_rw_data;
  logic [NUM_FWD-1:0]        fwd_write_ps;
  logic [NUM_FWD-1:0]        fwd_ps_data;
  logic                      iss_valid;
  logic                      iss_rw_use;
  logic [ADDR_W-1:0]         iss_rw_addr;
  logic                      iss_is_load;
  logic                      ld_done;
  logic [ADDR_W-1:0]         ld_addr;
  logic [DATA_W-1:0]         ld_data;
  logic [NUM_RD*DATA_W-1:0]  op_data;
  logic                      ps_data;
  logic                      stall;
  logic [NREG-1:0]           ld_pending;
  logic [CNT_W-1:0]          ld_count;

  int tests = 0;
  int fails = 0;

  operand_bypass_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
    .NUM_FWD(NUM_FWD), .MAX_LD(MAX_LD)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .rd_use(rd_use), .rd_addr(rd_addr), .rf_data(rf_data),
    .ps_use(ps_use), .rf_ps(rf_ps),
    .fwd_use_rw(fwd_use_rw), .fwd_rw_addr(fwd_rw_addr), .fwd_rw_data(fwd_rw_data),
    .fwd_write_ps(fwd_write_ps), .fwd_ps_data(fwd_ps_data),
    .iss_valid(iss_valid), .iss_rw_use(iss_rw_use), .iss_rw_addr(iss_rw_addr),
    .iss_is_load(iss_is_load),
    .ld_done(ld_done), .ld_addr(ld_addr), .ld_data(ld_data),
    .op_data(op_data), .ps_data(ps_data), .stall(stall),
    .ld_pending(ld_pending), .ld_count(ld_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rd_use;
    logic [7:0]  rd_addr;
    logic [31:0] rf_data;
    logic [1:0]  fwd_use_rw;
    logic [7:0]  fwd_rw_addr;
    logic [31:0] fwd_rw_data;
    logic        ps_use;
    logic        rf_ps;
    logic [1:0]  fwd_write_ps;
    logic [1:0]  fwd_ps_data;
    logic [31:0] exp_op;
    logic        exp_ps;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(
    input logic [1:0] ru, input logic [7:0] ra, input logic [31:0] rf,
    input logic [1:0] fu, input logic [7:0] fa, input logic [31:0] fd,
    input logic pu, input logic rp, input logic [1:0] fwp, input logic [1:0] fpd,
    input logic [31:0] eo, input logic ep);
    vec_t v;
    v.rd_use = ru; v.rd_addr = ra; v.rf_data = rf;
    v.fwd_use_rw = fu; v.fwd_rw_addr = fa; v.fwd_rw_data = fd;
    v.ps_use = pu; v.rf_ps = rp; v.fwd_write_ps = fwp; v.fwd_ps_data = fpd;
    v.exp_op = eo; v.exp_ps = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rd_use = '0; rd_addr = '0; rf_data = '0;
    ps_use = 1'b0; rf_ps = 1'b0;
    fwd_use_rw = '0; fwd_rw_addr = '0; fwd_rw_data = '0;
    fwd_write_ps = '0; fwd_ps_data = '0;
    iss_valid = 1'b0; iss_rw_use = 1'b0; iss_rw_addr = '0; iss_is_load = 1'b0;
    ld_done = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
  endtask

  task automatic issue_load(input logic [ADDR_W-1:0] r);
    idle();
    iss_valid = 1'b1; iss_is_load = 1'b1; iss_rw_use = 1'b1; iss_rw_addr = r;
    #1;
    chk("load_issue_no_stall", stall, 1'b0);
    next();
    idle();
  endtask

  initial begin
    // Operand/predicate resolution vectors (scoreboard empty, nothing issued)
    vecs[0] = mk(2'b11, {4'd4, 4'd3}, {16'hBBBB, 16'hAAAA}, 2'b11, {4'd3, 4'd3}, {16'h2222, 16'h1111},
                 1'b0, 1'b0, 2'b00, 2'b00, {16'hBBBB, 16'h1111}, 1'b0);
    vecs[1] = mk(2'b11, {4'd4, 4'd3}, {16'hBBBB, 16'hAAAA}, 2'b10, {4'd3, 4'd3}, {16'h2222, 16'h1111},
                 1'b0, 1'b0, 2'b00, 2'b00, {16'hBBBB, 16'h2222}, 1'b0);
    vecs[2] = mk(2'b11, {4'd4, 4'd3}, {16'hBBBB, 16'hAAAA}, 2'b00, {4'd3, 4'd3}, {16'h2222, 16'h1111},
                 1'b0, 1'b0, 2'b00, 2'b00, {16'hBBBB, 16'hAAAA}, 1'b0);
    vecs[3] = mk(2'b00, {4'd3, 4'd3}, {16'hBBBB, 16'hAAAA}, 2'b11, {4'd3, 4'd3}, {16'h2222, 16'h1111},
                 1'b0, 1'b0, 2'b00, 2'b00, {16'hBBBB, 16'hAAAA}, 1'b0);
    vecs[4] = mk(2'b11, {4'd4, 4'd3}, {16'hBBBB, 16'hAAAA}, 2'b11, {4'd4, 4'd3}, {16'h2222, 16'h1111},
                 1'b0, 1'b0, 2'b00, 2'b00, {16'h2222, 16'h1111}, 1'b0);
    vecs[5] = mk(2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0,
                 1'b1, 1'b0, 2'b10, 2'b10, 32'h0, 1'b1);
    vecs[6] = mk(2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0,
                 1'b1, 1'b1, 2'b11, 2'b10, 32'h0, 1'b0);
    vecs[7] = mk(2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0,
                 1'b0, 1'b0, 2'b10, 2'b10, 32'h0, 1'b0);
    vecs[8] = mk(2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0,
                 1'b1, 1'b1, 2'b00, 2'b11, 32'h0, 1'b1);

    // Reset state, with an instruction presented that would otherwise issue
    idle();
    n_rst = 1'b0;
    iss_valid = 1'b1; iss_is_load = 1'b1; iss_rw_use = 1'b1; iss_rw_addr = 4'd2;
    rd_use = 2'b01; rd_addr = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_pending", ld_pending, 16'h0000);
    chk("rst_count", ld_count, 3'd0);
    do_reset();

    for (int k = 0; k < 9; k++) begin
      idle();
      rd_use = vecs[k].rd_use; rd_addr = vecs[k].rd_addr; rf_data = vecs[k].rf_data;
      fwd_use_rw = vecs[k].fwd_use_rw; fwd_rw_addr = vecs[k].fwd_rw_addr;
      fwd_rw_data = vecs[k].fwd_rw_data;
      ps_use = vecs[k].ps_use; rf_ps = vecs[k].rf_ps;
      fwd_write_ps = vecs[k].fwd_write_ps; fwd_ps_data = vecs[k].fwd_ps_data;
      iss_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_op", k), op_data, vecs[k].exp_op);
      chk($sformatf("vec%0d_ps", k), ps_data, vecs[k].exp_ps);
      chk($sformatf("vec%0d_stall", k), stall, 1'b0);
      next();
    end

    // Load RAW on r5, completion with data 0xBEEF
    do_reset();
    issue_load(4'd5);
    chk("raw_pending", ld_pending, 16'h0020);
    chk("raw_count", ld_count, 3'd1);
    iss_valid = 1'b1; rd_use = 2'b01; rd_addr = 8'h05; rf_data = {16'h0000, 16'h1234};
    #1;
    chk("raw_stall", stall, 1'b1);
    ld_done = 1'b1; ld_addr = 4'd5; ld_data = 16'hBEEF;
    #1;
`ifdef OPERAND_BYPASS_LD_DONE_EN
    chk("raw_done_stall", stall, 1'b0);
    chk("raw_done_op", op_data[15:0], 16'hBEEF);
`else
    chk("raw_done_stall", stall, 1'b1);
    chk("raw_done_op", op_data[15:0], 16'h1234);
`endif
    next();
    ld_done = 1'b0;
    #1;
    chk("raw_after_stall", stall, 1'b0);
    chk("raw_after_op", op_data[15:0], 16'h1234);
    chk("raw_after_count", ld_count, 3'd0);
    chk("raw_after_pending", ld_pending, 16'h0000);

    // Capacity: four loads fill the scoreboard
    do_reset();
    issue_load(4'd1);
    issue_load(4'd2);
    issue_load(4'd3);
    issue_load(4'd4);
    chk("cap_count", ld_count, 3'd4);
    iss_valid = 1'b1; iss_is_load = 1'b1; iss_rw_use = 1'b1; iss_rw_addr = 4'd6;
    #1;
    chk("cap_full_stall", stall, 1'b1);
    ld_done = 1'b1; ld_addr = 4'd1;
    #1;
`ifdef OPERAND_BYPASS_LD_DONE_EN
    chk("cap_done_stall", stall, 1'b0);
`else
    chk("cap_done_stall", stall, 1'b1);
`endif
    next();
    idle();
    #1;
`ifdef OPERAND_BYPASS_LD_DONE_EN
    chk("cap_after_count", ld_count, 3'd4);
    chk("cap_after_pending", ld_pending, 16'h005C);
`else
    chk("cap_after_count", ld_count, 3'd3);
    chk("cap_after_pending", ld_pending, 16'h001C);
`endif

    // WAW and simultaneous set/clear on r7
    do_reset();
    issue_load(4'd7);
    iss_valid = 1'b1; iss_rw_use = 1'b1; iss_rw_addr = 4'd8;
    #1;
    chk("waw_other_reg", stall, 1'b0);
    iss_rw_addr = 4'd7;
    #1;
    chk("waw_stall", stall, 1'b1);
    iss_is_load = 1'b1; ld_done = 1'b1; ld_addr = 4'd7;
    #1;
`ifdef OPERAND_BYPASS_LD_DONE_EN
    chk("waw_done_stall", stall, 1'b0);
`else
    chk("waw_done_stall", stall, 1'b1);
`endif
    next();
    idle();
    #1;
`ifdef OPERAND_BYPASS_LD_DONE_EN
    chk("waw_setclr_pending", ld_pending, 16'h0080);
    chk("waw_setclr_count", ld_count, 3'd1);
`else
    chk("waw_setclr_pending", ld_pending, 16'h0000);
    chk("waw_setclr_count", ld_count, 3'd0);
`endif

    // Stray completion with nothing outstanding, then a load to r0
    do_reset();
    ld_done = 1'b1; ld_addr = 4'd0;
    next();
    idle();
    #1;
    chk("underflow_count", ld_count, 3'd0);
    chk("underflow_pending", ld_pending, 16'h0000);
    issue_load(4'd0);
    chk("r0_pending", ld_pending, 16'h0001);
    chk("r0_count", ld_count, 3'd1);

    // Asynchronous reset mid-run with three loads outstanding
    do_reset();
    issue_load(4'd1);
    issue_load(4'd2);
    issue_load(4'd3);
    chk("midrst_count_before", ld_count, 3'd3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_pending", ld_pending, 16'h0000);
    chk("midrst_count", ld_count, 3'd0);
    iss_valid = 1'b1; rd_use = 2'b01; rd_addr = 8'h01;
    #1;
    chk("midrst_stall", stall, 1'b0);
    next();
    n_rst = 1'b1;
    idle();
    ld_done = 1'b1; ld_addr = 4'd2;
    next();
    idle();
    #1;
    chk("midrst_stray_count", ld_count, 3'd0);
    chk("midrst_stray_pending", ld_pending, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
